// File: rtl/spi_flash_bridge.sv
// rtl/spi_flash_bridge.sv - byte read/program bridge from a parallel bus strobe to an SPI NOR flash
module spi_flash_bridge #(
  parameter int CLK_DIV  = 2,
  parameter int CS_GAP   = 4,
  parameter int POLL_MAX = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WREN = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_XFER = 3'd3;
  localparam logic [2:0] S_POLL = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  // Poll counter is at least 10 bits and grows if POLL_MAX needs more.
  localparam int PW = ($clog2(POLL_MAX + 1) > 10) ? $clog2(POLL_MAX + 1) : 10;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
  localparam logic [PW:0]   POLL_LIM = (PW + 1)'(POLL_MAX);

  logic [2:0]    r_state;
  logic [2:0]    r_gap_next;
  logic          r_we;
  logic [15:0]   r_addr;
  logic [7:0]    r_wdata;
  logic [7:0]    r_rdata;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          r_sck;
  logic          r_cs_n;
  logic [39:0]   r_tx;
  logic [7:0]    r_rx;
  logic [5:0]    r_bits;
  logic [7:0]    r_div;
  logic [GW-1:0] r_gap;
  logic [PW-1:0] r_poll;

  logic          w_launch;
  logic [2:0]    w_frame;
  logic          w_is_wr;
  logic [15:0]   w_addr;
  logic [7:0]    w_wdata;
  logic [39:0]   w_tx;
  logic [5:0]    w_bits;
  logic          w_in_frame;
  logic          w_tick;
  logic          w_poll_last;

  assign rdata    = r_rdata;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign spi_sck  = r_sck;
  assign spi_cs_n = r_cs_n;
  assign spi_mosi = r_tx[39];

  assign w_in_frame  = (r_state == S_WREN) || (r_state == S_XFER) || (r_state == S_POLL);
  assign w_tick      = (r_div == DIV_LAST);
  assign w_poll_last = ({1'b0, r_poll} + (PW + 1)'(1)) >= POLL_LIM;

  // Decide whether a frame starts this cycle and build its shift-out image (MSB first, left aligned).
  always_comb begin
    w_launch = 1'b0;
    w_frame  = S_IDLE;
    if (r_state == S_IDLE && req && !r_busy) begin
      w_launch = 1'b1;
      w_frame  = we ? S_WREN : S_XFER;
    end else if (r_state == S_GAP && r_gap == GAP_LAST) begin
      w_launch = 1'b1;
      w_frame  = r_gap_next;
    end
    w_is_wr = (r_state == S_IDLE) ? we    : r_we;
    w_addr  = (r_state == S_IDLE) ? addr  : r_addr;
    w_wdata = (r_state == S_IDLE) ? wdata : r_wdata;
    w_tx    = 40'h0;
    w_bits  = 6'd0;
    case (w_frame)
      S_WREN: begin
        w_tx   = {8'h06, 32'h0};
        w_bits = 6'd7;
      end
      S_XFER: begin
        w_tx   = w_is_wr ? {8'h02, 8'h00, w_addr, w_wdata} : {8'h03, 8'h00, w_addr, 8'h00};
        w_bits = 6'd39;
      end
      S_POLL: begin
        w_tx   = {8'h05, 32'h0};
        w_bits = 6'd15;
      end
      default: ;
    endcase
  end

  // Sequencer and SPI bit engine: cs_n, sck and the shift registers move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gap_next <= S_IDLE;
      r_we       <= 1'b0;
      r_addr     <= 16'h0;
      r_wdata    <= 8'h0;
      r_rdata    <= 8'h0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_sck      <= 1'b0;
      r_cs_n     <= 1'b1;
      r_tx       <= 40'h0;
      r_rx       <= 8'h0;
      r_bits     <= 6'd0;
      r_div      <= 8'd0;
      r_gap      <= '0;
      r_poll     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_launch) begin
        r_state <= w_frame;
        r_busy  <= 1'b1;
        r_cs_n  <= 1'b0;
        r_sck   <= 1'b0;
        r_div   <= 8'd0;
        r_tx    <= w_tx;
        r_bits  <= w_bits;
        if (r_state == S_IDLE) begin
          r_we    <= we;
          r_addr  <= addr;
          r_wdata <= wdata;
          r_poll  <= '0;
          r_err   <= 1'b0;
        end
      end else if (w_in_frame) begin
        if (!w_tick) begin
          r_div <= r_div + 8'd1;
        end else begin
          r_div <= 8'd0;
          if (!r_sck) begin
            // Rising edge: the flash has held miso since the previous falling edge.
            r_sck <= 1'b1;
            r_rx  <= {r_rx[6:0], spi_miso};
          end else begin
            r_sck <= 1'b0;
            if (r_bits != 6'd0) begin
              r_bits <= r_bits - 6'd1;
              r_tx   <= {r_tx[38:0], 1'b0};
            end else begin
              r_cs_n <= 1'b1;
              r_tx   <= 40'h0;
              case (r_state)
                S_WREN: begin
                  r_state    <= S_GAP;
                  r_gap      <= '0;
                  r_gap_next <= S_XFER;
                end
                S_XFER: begin
                  if (r_we) begin
                    r_state    <= S_GAP;
                    r_gap      <= '0;
                    r_gap_next <= S_POLL;
                  end else begin
                    r_rdata <= r_rx;
                    r_state <= S_FIN;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b0;
                  end
                end
                default: begin
                  // Status poll: WIP clear finishes, otherwise retry until the limit.
                  if (!r_rx[0] || w_poll_last) begin
                    r_state <= S_FIN;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_err   <= r_rx[0];
                  end else begin
                    r_poll     <= (r_poll == '1) ? r_poll : r_poll + PW'(1);
                    r_state    <= S_GAP;
                    r_gap      <= '0;
                    r_gap_next <= S_POLL;
                  end
                end
              endcase
            end
          end
        end
      end else if (r_state == S_GAP) begin
        r_gap <= r_gap + GW'(1);
      end else if (r_state == S_FIN) begin
        r_state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_bridge.sv
// tb/tb_spi_flash_bridge.sv - scoreboard bench for spi_flash_bridge with a behavioural SPI flash
module tb_spi_flash_bridge;

  localparam int CLK_DIV  = 2;
  localparam int CS_GAP   = 4;
  localparam int POLL_MAX = 5;

  typedef struct packed {
    logic [5:0]  bits;
    logic [39:0] data;
    logic [15:0] len;
  } frame_t;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  frame_t exp_frames[$];
  res_t   exp_res[$];

  logic [7:0] rbyte     = 8'h00;
  int         wip_polls = 0;
  int         abort_req = 0;

  spi_flash_bridge #(
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP),
    .POLL_MAX(POLL_MAX)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .spi_sck (spi_sck),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural flash: captures MOSI on SCK rise, drives MISO after SCK fall.
  logic [39:0] fl_cap   = 40'h0;
  int          fl_bcnt  = 0;
  logic [7:0]  fl_cmd   = 8'h00;
  logic        fl_cs_q  = 1'b1;
  logic        fl_sck_q = 1'b0;
  int          polls_seen = 0;
  logic [7:0]  fl_status;

  always @(spi_sck or spi_cs_n) begin
    if (spi_cs_n === 1'b0 && fl_cs_q !== 1'b0) begin
      fl_cap   = 40'h0;
      fl_bcnt  = 0;
      fl_cmd   = 8'h00;
      spi_miso = 1'b0;
    end else if (spi_cs_n === 1'b0 && spi_sck === 1'b1 && fl_sck_q !== 1'b1) begin
      fl_cap = {fl_cap[38:0], spi_mosi};
      fl_bcnt++;
      if (fl_bcnt == 8) fl_cmd = fl_cap[7:0];
    end else if (spi_cs_n === 1'b0 && spi_sck === 1'b0 && fl_sck_q === 1'b1) begin
      fl_status = {7'b0, (polls_seen < wip_polls)};
      if (fl_cmd == 8'h05 && fl_bcnt >= 8 && fl_bcnt < 16) spi_miso = fl_status[15 - fl_bcnt];
      else if (fl_cmd == 8'h03 && fl_bcnt >= 32 && fl_bcnt < 40) spi_miso = rbyte[39 - fl_bcnt];
      else spi_miso = 1'b0;
    end
    fl_cs_q  = spi_cs_n;
    fl_sck_q = spi_sck;
  end

  // Monitor: frame contents, cs_n low time, inter-frame gaps and done results.
  logic   mon_prev     = 1'b1;
  int     low_cnt      = 0;
  int     gap_cnt      = 0;
  int     frames_seen  = 0;
  int     abort_done   = 0;
  logic   gap_has_done = 1'b0;
  frame_t mon_f;
  res_t   mon_r;

  always @(negedge clk) begin
    if (spi_cs_n === 1'b0) begin
      if (mon_prev) begin
        if (!gap_has_done && frames_seen > 0) check_eq("cs_gap_min", 64'(gap_cnt >= CS_GAP), 64'd1);
        low_cnt = 0;
      end
      low_cnt++;
      mon_prev = 1'b0;
    end else if (spi_cs_n === 1'b1) begin
      if (!mon_prev) begin
        frames_seen++;
        if (abort_done != abort_req) begin
          abort_done++;
        end else if (exp_frames.size() == 0) begin
          check_eq("spurious_frame", 64'(fl_bcnt), 64'd0);
        end else begin
          mon_f = exp_frames.pop_front();
          check_eq("frame_bits", 64'(fl_bcnt), 64'(mon_f.bits));
          check_eq("frame_mosi", 64'(fl_cap), 64'(mon_f.data));
          check_eq("cs_low_cycles", 64'(low_cnt), 64'(mon_f.len));
        end
        if (fl_cmd == 8'h06) polls_seen = 0;
        if (fl_cmd == 8'h05) polls_seen++;
        gap_cnt      = 0;
        gap_has_done = 1'b0;
      end
      gap_cnt++;
      mon_prev = 1'b1;
    end
    if (done === 1'b1) begin
      gap_has_done = 1'b1;
      if (exp_res.size() == 0) begin
        check_eq("spurious_done", 64'(done), 64'd0);
      end else begin
        mon_r = exp_res.pop_front();
        check_eq("done_rdata", 64'(rdata), 64'(mon_r.rdata));
        check_eq("done_err", 64'(err), 64'(mon_r.err));
        check_eq("done_busy_low", 64'(busy), 64'd0);
        check_eq("done_cs_high", 64'(spi_cs_n), 64'd1);
      end
    end
  end

  task automatic push_frame(input logic [5:0] bits, input logic [39:0] data);
    frame_t f;
    f.bits = bits;
    f.data = data;
    f.len  = 16'(32'(bits) * 2 * CLK_DIV);
    exp_frames.push_back(f);
  endtask

  task automatic push_res(input logic [7:0] rd, input logic e);
    res_t r;
    r.rdata = rd;
    r.err   = e;
    exp_res.push_back(r);
  endtask

  task automatic do_req(input logic w, input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (done !== 1'b1) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    rst   = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    addr  = 16'h0;
    wdata = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cs_n", 64'(spi_cs_n), 64'd1);
    check_eq("rst_sck", 64'(spi_sck), 64'd0);
    check_eq("rst_mosi", 64'(spi_mosi), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_rdata", 64'(rdata), 64'h00);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Plain read
    rbyte = 8'hA5;
    push_frame(6'd40, 40'h03_00_12_34_00);
    push_res(8'hA5, 1'b0);
    do_req(1'b0, 16'h1234, 8'h00);
    check_eq("busy_after_accept", 64'(busy), 64'd1);
    wait_done("read");
    repeat (10) @(posedge clk);

    // Program with three busy polls then ready; rdata must hold
    wip_polls = 3;
    push_frame(6'd8, 40'h06);
    push_frame(6'd40, 40'h02_00_FF_FF_3C);
    for (int i = 0; i < 4; i++) push_frame(6'd16, 40'h05_00);
    push_res(8'hA5, 1'b0);
    do_req(1'b1, 16'hFFFF, 8'h3C);
    wait_done("program");
    repeat (10) @(posedge clk);

    // Program with WIP stuck: exactly POLL_MAX polls then err
    wip_polls = 1000;
    push_frame(6'd8, 40'h06);
    push_frame(6'd40, 40'h02_00_10_00_77);
    for (int i = 0; i < POLL_MAX; i++) push_frame(6'd16, 40'h05_00);
    push_res(8'hA5, 1'b1);
    do_req(1'b1, 16'h1000, 8'h77);
    wait_done("timeout");
    repeat (10) @(posedge clk);

    // Second req while busy must be ignored
    rbyte = 8'h5A;
    push_frame(6'd40, 40'h03_00_01_02_00);
    push_res(8'h5A, 1'b0);
    do_req(1'b0, 16'h0102, 8'h00);
    repeat (20) @(posedge clk);
    #1;
    req   = 1'b1;
    we    = 1'b1;
    addr  = 16'h7777;
    wdata = 8'hEE;
    @(posedge clk); #1;
    req = 1'b0;
    wait_done("busy_reject");
    repeat (300) @(posedge clk);

    // Reset during the third address byte
    rbyte = 8'hEE;
    do_req(1'b0, 16'hBEEF, 8'h00);
    repeat (105) @(posedge clk);
    #1;
    abort_req++;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_cs_n", 64'(spi_cs_n), 64'd1);
    check_eq("abort_sck", 64'(spi_sck), 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_rdata", 64'(rdata), 64'h00);
    rst = 1'b0;
    repeat (50) @(posedge clk);
    rbyte = 8'h99;
    push_frame(6'd40, 40'h03_00_43_21_00);
    push_res(8'h99, 1'b0);
    do_req(1'b0, 16'h4321, 8'h00);
    wait_done("post_reset_read");
    repeat (10) @(posedge clk);

    // Back-to-back: req in FIN ignored, req in following IDLE accepted
    rbyte = 8'h11;
    push_frame(6'd40, 40'h03_00_00_10_00);
    push_res(8'h11, 1'b0);
    do_req(1'b0, 16'h0010, 8'h00);
    wait_done("b2b_first");
    push_frame(6'd40, 40'h03_00_00_20_00);
    push_res(8'h22, 1'b0);
    req  = 1'b1;
    we   = 1'b0;
    addr = 16'h00AA;
    @(posedge clk); #1;
    addr = 16'h0020;
    @(posedge clk); #1;
    req = 1'b0;
    check_eq("b2b_busy", 64'(busy), 64'd1);
    rbyte = 8'h22;
    repeat (100) @(posedge clk);
    #1;
    check_eq("b2b_rdata_hold", 64'(rdata), 64'h11);
    wait_done("b2b_second");
    repeat (20) @(posedge clk);

    check_eq("frames_left", 64'(exp_frames.size()), 64'd0);
    check_eq("results_left", 64'(exp_res.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_bridge.md
SPI_FLASH_BRIDGE -- requirements
Module: spi_flash_bridge

Interface
REQ-001 Parameter CLK_DIV, default 2, meaning clk cycles per SCK half-period (legal range 1..255).
REQ-002 Parameter CS_GAP, default 4, meaning minimum clk cycles spi_cs_n is held high between SPI frames.
REQ-003 Parameter POLL_MAX, default 1023, meaning maximum status-poll frames after a program before an error is reported.
REQ-004 clk  input  1  sole clock; all state updates on the posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  1  one-cycle request strobe from the memory-select logic (flash OE_/WE_ decode).
REQ-007 we  input  1  sampled with req; 1 = byte program, 0 = byte read.
REQ-008 addr  input  16  flash byte address, sampled with req.
REQ-009 wdata  input  8  program data, sampled with req.
REQ-010 rdata  output  8  read result, drives the 8-bit data bus via an external tri-state.
REQ-011 busy  output  1  high from the cycle after acceptance until done.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  valid with done; 1 = program poll timeout.
REQ-014 spi_sck, spi_cs_n, spi_mosi  output  1 each  SPI mode 0 master pins.
REQ-015 spi_miso  input  1  SPI data from the flash.

Function
REQ-016 An accepted req SHALL capture we, addr and wdata; req SHALL be accepted only when the block is in IDLE and busy is 0, and SHALL be ignored otherwise.
REQ-017 States SHALL be: IDLE, WREN, GAP, XFER, POLL, FIN.
REQ-018 SPI signalling: MSB first; spi_sck idles low; spi_mosi changes only while spi_sck is low; spi_miso is sampled in the clk cycle in which spi_sck rises.
REQ-019 Bit timing: each bit SHALL last 2*CLK_DIV clk cycles, with spi_sck low for CLK_DIV cycles and then high for CLK_DIV cycles.
REQ-020 A frame SHALL begin with spi_cs_n going low in the cycle after the frame starts, and SHALL end with spi_cs_n going high in the cycle after the last low-to-high-to-low SCK phase.
REQ-021 Read (we=0): IDLE->XFER; the frame is 0x03, then 0x00, then addr[15:8], addr[7:0], then 8 bits received into rdata; FIN follows.
REQ-022 Program (we=1), write-enable phase: IDLE->WREN, which sends the single-byte frame 0x06; then GAP for CS_GAP cycles.
REQ-023 Program, data phase: after GAP, XFER sends 0x02, 0x00, addr[15:8], addr[7:0], wdata; then GAP for CS_GAP cycles; then POLL.
REQ-024 POLL SHALL send frames of 0x05 followed by 8 received status bits, separated by CS_GAP-cycle gaps.
REQ-025 POLL exit on completion: when status bit0 (WIP) is 0, the state SHALL go to FIN with err=0.
REQ-026 POLL exit on timeout: when a POLL_MAX-th frame still returns WIP=1, the state SHALL go to FIN with err=1.
REQ-027 Poll counting SHALL use a 10-bit counter (or wider, if POLL_MAX requires it) that saturates and never wraps.
REQ-028 In FIN, done SHALL be 1 for one cycle coincident with spi_cs_n high, busy SHALL drop in that same cycle, and the next state is IDLE.
REQ-029 rdata SHALL update only at the end of a read frame and SHALL hold its value through programs and idle periods.
REQ-030 A read SHALL hold spi_cs_n low for exactly 40*2*CLK_DIV cycles.
REQ-031 A req arriving in the FIN cycle SHALL be ignored; a req arriving in the following IDLE cycle SHALL be accepted.

Reset
REQ-032 On rst: state=IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, busy=0, done=0, err=0, rdata=0x00, and all counters cleared.
REQ-033 rst asserted mid-frame SHALL force spi_cs_n high and spi_sck low at the next posedge, and no done pulse SHALL be generated for the aborted request.

Verification
REQ-034 Read: CLK_DIV=2, addr=0x1234, flash model returns 0xA5 -> MOSI carries 03 00 12 34, spi_cs_n is low for 160 cycles, done pulses with rdata=0xA5 and err=0.
REQ-035 Program: addr=0xFFFF, wdata=0x3C, WIP=1 for 3 polls then 0 -> frames 06 | 02 00 FF FF 3C | 4 status polls, each gap >=4 cycles; done pulses with err=0.
REQ-036 Timeout: POLL_MAX=5 and WIP stuck at 1 -> exactly 5 poll frames are sent, then done pulses with err=1.
REQ-037 Busy rejection: a second req with a different addr while busy -> no extra frame is sent, and the first transaction completes unchanged.
REQ-038 Reset mid-transfer: rst asserted during the third address byte -> spi_cs_n=1 and spi_sck=0 on the next cycle, no done pulse, and a new read afterwards completes correctly.
REQ-039 Back-to-back: a req one cycle after done -> it is accepted, and rdata from the prior read holds its value until the new read frame ends.
